l1d_port_arbiter: RTL and testbench
===================================

Name: l1d_port_arbiter

Overview:
- Shares the single-port L1D SRAM between two requesters: the load path (memory-access stage) and the store-buffer drain path.
- Grants at most one access per cycle and drives the registered SRAM command.
- Tracks in-flight reads with a fixed-latency valid/tag pipeline and returns read data to the load path tagged with the issuing instruction id.
- Sits between the memory stage / store buffer and the L1D macro.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TAGW, 8, load tag width (instruction/ROB id).
- RD_LAT, 1, SRAM read latency in cycles from re_o high to sram_rdata_i valid; legal range 1..4.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which a waiting store wins; legal range 1..15.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- ld_req_i  in  1  load request valid.
- ld_addr_i  in  AW  load byte address.
- ld_tag_i  in  TAGW  load tag.
- ld_gnt_o  out  1  load accepted this cycle (combinational).
- st_req_i  in  1  store request valid.
- st_addr_i  in  AW  store byte address.
- st_wdata_i  in  DW  store data, lane-aligned.
- st_wmask_i  in  DW/8  byte write mask.
- st_gnt_o  out  1  store accepted this cycle (combinational).
- flush_i  in  1  pipeline flush; kills pending load responses.
- re_o  out  1  SRAM read enable.
- we_o  out  1  SRAM write enable.
- addr_o  out  AW  SRAM address.
- wdata_o  out  DW  SRAM write data.
- wmask_o  out  DW/8  SRAM byte mask.
- sram_rdata_i  in  DW  SRAM read data.
- ld_rvalid_o  out  1  load response valid.
- ld_rtag_o  out  TAGW  tag of the returning load.
- ld_rdata_o  out  DW  returned read data.

Behaviour:
- Reset (async, immediate): re_o=0, we_o=0, addr_o=0, wdata_o=0, wmask_o=0, ld_rvalid_o=0, ld_rtag_o=0, ld_rdata_o=0, starve_cnt=0, all response-pipeline valids=0. Grants are 0 while rst is high.
- Arbitration (combinational, evaluated each cycle):
  - Neither request: no grant.
  - Only one request: grant it, except a load while flush_i=1.
  - Both requesting and ld_addr_i[AW-1:2]==st_addr_i[AW-1:2]: store wins (older committed store must reach the SRAM first).
  - Both requesting and starve_cnt==STARVE_LIMIT: store wins.
  - Otherwise load wins.
  - flush_i=1: ld_gnt_o forced 0; stores are still granted.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when st_req_i=1 and st_gnt_o=0.
  - Clears to 0 when st_gnt_o=1 or st_req_i=0.
- Command register (posedge after grant, cycle T+1):
  - Load grant: re_o=1, we_o=0, addr_o=ld_addr_i, wmask_o=0.
  - Store grant: we_o=1, re_o=0, addr_o=st_addr_i, wdata_o=st_wdata_i, wmask_o=st_wmask_i.
  - No grant: re_o=0, we_o=0; addr_o, wdata_o and wmask_o hold their values.
  - re_o and we_o are never both 1.
- Response pipeline:
  - Shift register of RD_LAT+1 stages of {valid, tag}.
  - Stage 0 is loaded with {re_o, captured tag} when the command is issued.
  - When the final stage is valid: ld_rvalid_o=1, ld_rtag_o=tag, ld_rdata_o=sram_rdata_i, all registered.
  - Load accepted at T gives ld_rvalid_o at T+2+RD_LAT (T+3 for RD_LAT=1).
  - Back-to-back loads return one per cycle, in order. There is no backpressure on the response; the consumer must accept every response.
- Flush:
  - All pipeline valid bits cleared at the posedge where flush_i=1.
  - ld_rvalid_o is 0 the following cycle.
  - Any load command registered during the flush cycle produces no response.
  - Writes already issued complete normally.
- Stores: no response; the store is complete once we_o is seen.
- Mid-operation reset clears everything immediately; in-flight reads are dropped silently.

Test Plan:
- Single load: rst released; ld_req_i=1 one cycle with ld_addr_i=0x0000_0100, ld_tag_i=0x2A; sram_rdata_i=0xDEAD_BEEF at T+2 -> ld_gnt_o=1 at T; re_o=1 and addr_o=0x100 at T+1; ld_rvalid_o=1, ld_rtag_o=0x2A, ld_rdata_o=0xDEADBEEF at T+3; no other rvalid.
- Starvation: ld_req_i held high with distinct addresses; st_req_i high from cycle 0 at addr 0x200 -> loads granted cycles 0-3; st_gnt_o=1 in cycle 4; we_o=1 with addr_o=0x200 in cycle 5; starve_cnt back to 0.
- Same-word hazard: ld_addr_i=0x0000_0104, st_addr_i=0x0000_0106 in the same cycle -> st_gnt_o=1, ld_gnt_o=0; load granted the next cycle.
- Flush: three back-to-back loads with tags 1, 2, 3; flush_i pulsed the cycle after tag 3 is granted -> no ld_rvalid_o for tags 2 and 3; a store requested during the flush is still granted.
- Async reset: assert rst mid-cycle while re_o=1 with a load in flight -> re_o, ld_rvalid_o and starve_cnt go to 0 before the next clock edge; no response after release.
- RD_LAT=3 build: alternating load/store stream -> every load returns exactly 5 cycles after its grant with the matching tag; re_o and we_o are never high together.

Source files
------------

// File: rtl/l1d_port_arbiter.sv
// Single-port L1D arbiter: grants one of load / store-drain per cycle, registers the
// SRAM command, and returns tagged read data through a fixed-latency valid/tag pipe.
module l1d_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int TAGW         = 8,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req_i,
  input  logic [AW-1:0]     ld_addr_i,
  input  logic [TAGW-1:0]   ld_tag_i,
  output logic              ld_gnt_o,
  input  logic              st_req_i,
  input  logic [AW-1:0]     st_addr_i,
  input  logic [DW-1:0]     st_wdata_i,
  input  logic [DW/8-1:0]   st_wmask_i,
  output logic              st_gnt_o,
  input  logic              flush_i,
  output logic              re_o,
  output logic              we_o,
  output logic [AW-1:0]     addr_o,
  output logic [DW-1:0]     wdata_o,
  output logic [DW/8-1:0]   wmask_o,
  input  logic [DW-1:0]     sram_rdata_i,
  output logic              ld_rvalid_o,
  output logic [TAGW-1:0]   ld_rtag_o,
  output logic [DW-1:0]     ld_rdata_o
);

  localparam int NSTG = RD_LAT + 1;
  localparam int MW   = DW / 8;

  logic            same_word;
  logic            starved;
  logic            ld_ok;
  logic            ld_gnt;
  logic            st_gnt;

  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic            re_q, re_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic [NSTG-1:0] pv_q, pv_d;
  logic [TAGW-1:0] pt_q [NSTG];
  logic [TAGW-1:0] pt_d [NSTG];
  logic            rvalid_q, rvalid_d;
  logic [TAGW-1:0] rtag_q, rtag_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  // A store to the same word must land before a younger load can read it.
  assign same_word = (ld_addr_i[AW-1:2] == st_addr_i[AW-1:2]);
  assign starved   = (starve_cnt_q == 4'(STARVE_LIMIT));
  assign ld_ok     = ld_req_i & ~flush_i & ~rst;
  assign st_gnt    = st_req_i & ~rst & (~ld_ok | same_word | starved);
  assign ld_gnt    = ld_ok & ~st_gnt;
  assign ld_gnt_o  = ld_gnt;
  assign st_gnt_o  = st_gnt;

  always_comb begin
    starve_cnt_d = '0;
    if (st_req_i && !st_gnt) begin
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    re_d    = ld_gnt;
    we_d    = st_gnt;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    if (st_gnt) begin
      addr_d  = st_addr_i;
      wdata_d = st_wdata_i;
      wmask_d = st_wmask_i;
    end else if (ld_gnt) begin
      addr_d  = ld_addr_i;
      wmask_d = '0;
    end
  end

  // Stage 0 fills alongside re_o, so the last stage lines up with valid SRAM data.
  always_comb begin
    pv_d    = '0;
    pv_d[0] = ld_gnt;
    pt_d[0] = ld_tag_i;
    for (int i = 1; i < NSTG; i++) begin
      pv_d[i] = pv_q[i-1] & ~flush_i;
      pt_d[i] = pt_q[i-1];
    end
  end

  always_comb begin
    rvalid_d = pv_q[NSTG-1] & ~flush_i;
    rtag_d   = rtag_q;
    rdata_d  = rdata_q;
    if (rvalid_d) begin
      rtag_d  = pt_q[NSTG-1];
      rdata_d = sram_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      pv_q         <= '0;
      for (int i = 0; i < NSTG; i++) begin
        pt_q[i] <= '0;
      end
      rvalid_q     <= 1'b0;
      rtag_q       <= '0;
      rdata_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      re_q         <= re_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      pv_q         <= pv_d;
      for (int i = 0; i < NSTG; i++) begin
        pt_q[i] <= pt_d[i];
      end
      rvalid_q     <= rvalid_d;
      rtag_q       <= rtag_d;
      rdata_q      <= rdata_d;
    end
  end

  assign re_o        = re_q;
  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign wmask_o     = wmask_q;
  assign ld_rvalid_o = rvalid_q;
  assign ld_rtag_o   = rtag_q;
  assign ld_rdata_o  = rdata_q;

endmodule

// File: tb/tb_l1d_port_arbiter.sv
// Bench for l1d_port_arbiter: RD_LAT=1 and RD_LAT=3 instances share stimulus and are
// checked each cycle against a queue-based model, plus directed literal scenarios.
module tb_l1d_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_req_i = 1'b0;
  logic [31:0] ld_addr_i = '0;
  logic [7:0]  ld_tag_i = '0;
  logic        st_req_i = 1'b0;
  logic [31:0] st_addr_i = '0;
  logic [31:0] st_wdata_i = '0;
  logic [3:0]  st_wmask_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] sram_rdata_i = '0;

  logic [1:0]       ld_gnt, st_gnt, re, we, rvalid;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][3:0]  wmask;
  logic [1:0][7:0]  rtag;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  l1d_port_arbiter #(.RD_LAT(1), .STARVE_LIMIT(LIMIT)) dut1 (
    .clk(clk), .rst(rst),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_tag_i(ld_tag_i), .ld_gnt_o(ld_gnt[0]),
    .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_wdata_i(st_wdata_i),
    .st_wmask_i(st_wmask_i), .st_gnt_o(st_gnt[0]), .flush_i(flush_i),
    .re_o(re[0]), .we_o(we[0]), .addr_o(addr[0]), .wdata_o(wdata[0]), .wmask_o(wmask[0]),
    .sram_rdata_i(sram_rdata_i), .ld_rvalid_o(rvalid[0]), .ld_rtag_o(rtag[0]),
    .ld_rdata_o(rdata[0])
  );

  l1d_port_arbiter #(.RD_LAT(3), .STARVE_LIMIT(LIMIT)) dut3 (
    .clk(clk), .rst(rst),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_tag_i(ld_tag_i), .ld_gnt_o(ld_gnt[1]),
    .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_wdata_i(st_wdata_i),
    .st_wmask_i(st_wmask_i), .st_gnt_o(st_gnt[1]), .flush_i(flush_i),
    .re_o(re[1]), .we_o(we[1]), .addr_o(addr[1]), .wdata_o(wdata[1]), .wmask_o(wmask[1]),
    .sram_rdata_i(sram_rdata_i), .ld_rvalid_o(rvalid[1]), .ld_rtag_o(rtag[1]),
    .ld_rdata_o(rdata[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Arbitration rules: returns {store_grant, load_grant}.
  function automatic logic [1:0] exp_gnt(input logic r, input logic lr, input logic sr,
                                         input logic fl, input logic [31:0] la,
                                         input logic [31:0] sa, input int sc);
    logic ld_ok;
    if (r) return 2'b00;
    ld_ok = lr && !fl;
    if (sr && ld_ok) begin
      if ((la >> 2) == (sa >> 2) || sc == LIMIT) return 2'b10;
      return 2'b01;
    end
    return {sr, ld_ok};
  endfunction

  // Model: pending loads are kept as (due cycle, tag) entries per read latency.
  typedef struct {
    int         due;
    logic [7:0] tag;
  } resp_t;

  resp_t       q_a[$];
  resp_t       q_b[$];
  resp_t       r_m;
  int          cyc = 0;
  int          m_starve = 0;
  logic [1:0]  g_m;
  logic        m_re = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_wmask = '0;
  logic [1:0]  m_rv = '0;
  logic [1:0][7:0]  m_tag;
  logic [1:0][31:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_starve = 0; m_re = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
      m_rv = '0;
      q_a.delete();
      q_b.delete();
    end else begin
      g_m  = exp_gnt(rst, ld_req_i, st_req_i, flush_i, ld_addr_i, st_addr_i, m_starve);
      m_rv = '0;
      if (q_a.size() != 0 && q_a[0].due == cyc + 1) begin
        r_m = q_a.pop_front();
        if (!flush_i) begin m_rv[0] = 1'b1; m_tag[0] = r_m.tag; m_data[0] = sram_rdata_i; end
      end
      if (q_b.size() != 0 && q_b[0].due == cyc + 1) begin
        r_m = q_b.pop_front();
        if (!flush_i) begin m_rv[1] = 1'b1; m_tag[1] = r_m.tag; m_data[1] = sram_rdata_i; end
      end
      if (flush_i) begin
        q_a.delete();
        q_b.delete();
      end
      if (g_m[0]) begin
        q_a.push_back('{cyc + 3, ld_tag_i});
        q_b.push_back('{cyc + 5, ld_tag_i});
      end
      m_re = g_m[0];
      m_we = g_m[1];
      if (g_m[1]) begin
        m_addr = st_addr_i; m_wdata = st_wdata_i; m_wmask = st_wmask_i;
      end else if (g_m[0]) begin
        m_addr = ld_addr_i; m_wmask = '0;
      end
      if (st_req_i && !g_m[1]) m_starve = (m_starve < LIMIT) ? m_starve + 1 : m_starve;
      else m_starve = 0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [1:0] g;
    g = exp_gnt(rst, ld_req_i, st_req_i, flush_i, ld_addr_i, st_addr_i, m_starve);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("L%0d.ld_gnt", k*2+1), ld_gnt[k], g[0]);
      chk($sformatf("L%0d.st_gnt", k*2+1), st_gnt[k], g[1]);
      chk($sformatf("L%0d.re_o", k*2+1), re[k], m_re);
      chk($sformatf("L%0d.we_o", k*2+1), we[k], m_we);
      chk($sformatf("L%0d.re_we_excl", k*2+1), re[k] & we[k], 1'b0);
      chk($sformatf("L%0d.addr_o", k*2+1), addr[k], m_addr);
      chk($sformatf("L%0d.wdata_o", k*2+1), wdata[k], m_wdata);
      chk($sformatf("L%0d.wmask_o", k*2+1), wmask[k], m_wmask);
      chk($sformatf("L%0d.rvalid", k*2+1), rvalid[k], m_rv[k]);
      if (m_rv[k]) begin
        chk($sformatf("L%0d.rtag", k*2+1), rtag[k], m_tag[k]);
        chk($sformatf("L%0d.rdata", k*2+1), rdata[k], m_data[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    sram_rdata_i = $urandom;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      ld_req_i = 1'b0; st_req_i = 1'b0; flush_i = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset.re_o", re, 2'b00);
    chk("reset.rvalid", rvalid, 2'b00);
    chk("reset.addr_o", addr[0], 32'h0);
    rst = 1'b0;
    idle(2);

    // Single load
    step();
    ld_req_i = 1'b1; ld_addr_i = 32'h0000_0100; ld_tag_i = 8'h2A;
    settle(); chk("single.ld_gnt", ld_gnt, 2'b11);
    step(); ld_req_i = 1'b0;
    settle(); chk("single.re_o", re[0], 1'b1); chk("single.addr_o", addr[0], 32'h100);
    step(); sram_rdata_i = 32'hDEAD_BEEF;
    settle(); chk("single.early_rvalid", rvalid, 2'b00);
    step();
    settle(); chk("single.rvalid", rvalid, 2'b01);
    chk("single.rtag", rtag[0], 8'h2A); chk("single.rdata", rdata[0], 32'hDEAD_BEEF);
    step(); sram_rdata_i = 32'hCAFE_F00D;
    settle(); chk("single.rvalid_gone", rvalid[0], 1'b0);
    step();
    settle(); chk("single.l3_rvalid", rvalid, 2'b10);
    chk("single.l3_rtag", rtag[1], 8'h2A); chk("single.l3_rdata", rdata[1], 32'hCAFE_F00D);
    idle(6);

    // Starvation
    for (int i = 0; i < 6; i++) begin
      step();
      ld_req_i = 1'b1; ld_addr_i = 32'h1000 + 32'(16*i); ld_tag_i = 8'(8'h40 + i);
      st_req_i = (i <= 4); st_addr_i = 32'h200; st_wdata_i = 32'h5555_AAAA; st_wmask_i = 4'hF;
      settle();
      if (i < 4) begin
        chk("starve.ld_gnt", ld_gnt[0], 1'b1); chk("starve.st_gnt", st_gnt[0], 1'b0);
      end else if (i == 4) begin
        chk("starve.st_win", st_gnt[0], 1'b1); chk("starve.ld_lose", ld_gnt[0], 1'b0);
      end else begin
        chk("starve.we_o", we[0], 1'b1); chk("starve.addr_o", addr[0], 32'h200);
        chk("starve.cnt_clr", dut1.starve_cnt_q, 4'd0);
      end
    end
    idle(7);

    // Same-word hazard
    step();
    ld_req_i = 1'b1; ld_addr_i = 32'h104; ld_tag_i = 8'h11;
    st_req_i = 1'b1; st_addr_i = 32'h106;
    settle(); chk("hazard.st_gnt", st_gnt[0], 1'b1); chk("hazard.ld_gnt", ld_gnt[0], 1'b0);
    step(); st_req_i = 1'b0;
    settle(); chk("hazard.ld_next", ld_gnt[0], 1'b1);
    idle(7);

    // Flush
    for (int i = 1; i <= 3; i++) begin
      step();
      ld_req_i = 1'b1; ld_tag_i = 8'(i); ld_addr_i = 32'h300 + 32'(4*i);
    end
    step();
    flush_i = 1'b1; ld_tag_i = 8'h04; st_req_i = 1'b1; st_addr_i = 32'h400;
    settle();
    chk("flush.ld_gnt", ld_gnt[0], 1'b0); chk("flush.st_gnt", st_gnt[0], 1'b1);
    chk("flush.tag1_rvalid", rvalid, 2'b01); chk("flush.tag1", rtag[0], 8'h01);
    for (int i = 0; i < 8; i++) begin
      step(); flush_i = 1'b0; ld_req_i = 1'b0; st_req_i = 1'b0;
      settle(); chk("flush.killed", rvalid, 2'b00);
    end

    // Asynchronous reset with a read in flight
    step();
    ld_req_i = 1'b1; ld_addr_i = 32'h500; ld_tag_i = 8'h77;
    st_req_i = 1'b1; st_addr_i = 32'h600;
    step(); ld_req_i = 1'b0;
    settle(); chk("areset.re_before", re, 2'b11);
    chk("areset.cnt_before", dut1.starve_cnt_q, 4'd1);
    rst = 1'b1;
    #1;
    chk("areset.re_o", re, 2'b00); chk("areset.rvalid", rvalid, 2'b00);
    chk("areset.cnt", dut1.starve_cnt_q, 4'd0); chk("areset.st_gnt", st_gnt, 2'b00);
    step(); st_req_i = 1'b0;
    step(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(); settle(); chk("areset.no_resp", rvalid, 2'b00);
    end

    // Alternating load/store stream
    for (int i = 0; i < 12; i++) begin
      step();
      ld_req_i = (i % 2 == 0); st_req_i = (i % 2 == 1);
      ld_tag_i = 8'(8'h80 + i); ld_addr_i = 32'h700 + 32'(4*i);
      st_addr_i = 32'h900 + 32'(4*i); st_wdata_i = $urandom; st_wmask_i = 4'($urandom);
      settle();
      if (i == 4) chk("alt.l3_early", rvalid[1], 1'b0);
      if (i == 5) begin
        chk("alt.l3_rvalid", rvalid[1], 1'b1); chk("alt.l3_rtag", rtag[1], 8'h80);
      end
    end
    idle(8);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rst        = ($urandom_range(0, 499) == 0);
      ld_req_i   = ($urandom_range(0, 9) < 6);
      ld_addr_i  = 32'h800 + 32'($urandom_range(0, 15));
      ld_tag_i   = 8'($urandom);
      st_req_i   = ($urandom_range(0, 1) == 1);
      st_addr_i  = 32'h800 + 32'($urandom_range(0, 15));
      st_wdata_i = $urandom;
      st_wmask_i = 4'($urandom);
      flush_i    = ($urandom_range(0, 29) == 0);
    end
    step(); rst = 1'b0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
